// File: rtl/miriscv_pkg.sv
// Shared LSU definitions: access size encodings, FSM state enum and byte-lane helpers.
package miriscv_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ1,
    LSU_WAIT1,
    LSU_REQ2,
    LSU_WAIT2,
    LSU_DONE,
    LSU_ERR
  } lsu_state_e;

  // Byte-lane mask of an access placed at lane 0; encoding 11 behaves as a word.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_mask = 4'b0001;
      SIZE_HALF: size_mask = 4'b0011;
      default:   size_mask = 4'b1111;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [1:0] size_align_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_align_mask = 2'b00;
      SIZE_HALF: size_align_mask = 2'b01;
      default:   size_align_mask = 2'b11;
    endcase
  endfunction

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    be_to_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// Combinational lane logic: byte enables for both beats, store-data rotation,
// load-beat merge, rotation back to bit 0 and sign/zero extension.
module miriscv_lsu_align
  import miriscv_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] buf0_i,
  input  logic [31:0] buf1_i,
  output logic [3:0]  be1_o,
  output logic [3:0]  be2_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  be_wide;
  logic [5:0]  sh;
  logic [31:0] merged;
  logic [31:0] aligned;

  always_comb begin
    sh      = {1'b0, off_i, 3'b000};
    // Lanes shifted past bit 3 spill into the second word.
    be_wide = {4'b0000, size_mask(size_i)} << off_i;
    be1_o   = be_wide[3:0];
    be2_o   = be_wide[7:4];
    wdata_o = (wdata_i << sh) | (wdata_i >> (6'd32 - sh));
    merged  = (buf0_i & be_to_mask(be1_o)) | (buf1_i & be_to_mask(be2_o));
    aligned = (merged >> sh) | (merged << (6'd32 - sh));
    case (size_i)
      SIZE_BYTE: rdata_o = {{24{aligned[7] & ~unsigned_i}}, aligned[7:0]};
      SIZE_HALF: rdata_o = {{16{aligned[15] & ~unsigned_i}}, aligned[15:0]};
      default:   rdata_o = aligned;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: turns one core access into one or two aligned bus beats,
// with optional splitting of word-crossing accesses.
module miriscv_lsu
  import miriscv_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_unsigned_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic              lsu_ready_o,
  output logic              lsu_valid_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_misalign_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i
);

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf0_q, buf0_d;
  logic [31:0]       buf1_q, buf1_d;
  logic              data_req_q, data_req_d;
  logic              data_we_q, data_we_d;
  logic [3:0]        data_be_q, data_be_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [31:0]       data_wdata_q, data_wdata_d;

  logic              idle;
  logic              cur_we;
  logic [1:0]        cur_size;
  logic              cur_uns;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [ADDR_W-1:0] base_addr;
  logic [3:0]        be1, be2;
  logic [31:0]       wdata_rot, load_data;
  logic              split, misalign_err;

  // While idle the lane logic looks at the incoming request so the first beat
  // can be registered on the accepting edge; afterwards it uses the latched copy.
  always_comb begin
    idle      = (state_q == LSU_IDLE);
    cur_we    = idle ? lsu_we_i       : we_q;
    cur_size  = idle ? lsu_size_i     : size_q;
    cur_uns   = idle ? lsu_unsigned_i : uns_q;
    cur_addr  = idle ? lsu_addr_i     : addr_q;
    cur_wdata = idle ? lsu_wdata_i    : wdata_q;
    base_addr = {cur_addr[ADDR_W-1:2], 2'b00};
    split     = |be2;
    misalign_err = !MISALIGNED_EN && |(lsu_addr_i[1:0] & size_align_mask(lsu_size_i));
  end

  miriscv_lsu_align u_align (
    .size_i     (cur_size),
    .off_i      (cur_addr[1:0]),
    .unsigned_i (cur_uns),
    .wdata_i    (cur_wdata),
    .buf0_i     (buf0_q),
    .buf1_i     (buf1_q),
    .be1_o      (be1),
    .be2_o      (be2),
    .wdata_o    (wdata_rot),
    .rdata_o    (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= LSU_IDLE;
      buf0_q       <= '0;
      buf1_q       <= '0;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= '0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      data_req_q   <= data_req_d;
      data_we_q    <= data_we_d;
      data_be_q    <= data_be_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:  if (lsu_req_i) state_d = misalign_err ? LSU_ERR : LSU_REQ1;
      LSU_REQ1:  if (data_gnt_i) state_d = LSU_WAIT1;
      LSU_WAIT1: if (data_rvalid_i) state_d = split ? LSU_REQ2 : LSU_DONE;
      LSU_REQ2:  if (data_gnt_i) state_d = LSU_WAIT2;
      LSU_WAIT2: if (data_rvalid_i) state_d = LSU_DONE;
      LSU_DONE:  state_d = LSU_IDLE;
      LSU_ERR:   state_d = LSU_IDLE;
      default:   state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (idle && lsu_req_i) begin
      we_d    = lsu_we_i;
      size_d  = lsu_size_i;
      uns_d   = lsu_unsigned_i;
      addr_d  = lsu_addr_i;
      wdata_d = lsu_wdata_i;
    end
    buf0_d = (state_q == LSU_WAIT1 && data_rvalid_i) ? data_rdata_i : buf0_q;
    buf1_d = (state_q == LSU_WAIT2 && data_rvalid_i) ? data_rdata_i : buf1_q;

    // Bus request is registered from the upcoming state; recomputing from the
    // latched access keeps it stable while the grant is withheld.
    data_req_d   = (state_d == LSU_REQ1) || (state_d == LSU_REQ2);
    data_we_d    = data_req_d ? cur_we : 1'b0;
    data_wdata_d = data_req_d ? wdata_rot : '0;
    data_be_d    = '0;
    data_addr_d  = '0;
    if (state_d == LSU_REQ1) begin
      data_be_d   = be1;
      data_addr_d = base_addr;
    end else if (state_d == LSU_REQ2) begin
      data_be_d   = be2;
      data_addr_d = base_addr + WORD_STEP;
    end
  end

  always_comb begin
    lsu_ready_o    = idle;
    lsu_valid_o    = (state_q == LSU_DONE) || (state_q == LSU_ERR);
    lsu_misalign_o = (state_q == LSU_ERR);
    lsu_rdata_o    = (state_q == LSU_DONE && !we_q) ? load_data : '0;
    data_req_o     = data_req_q;
    data_we_o      = data_we_q;
    data_be_o      = data_be_q;
    data_addr_o    = data_addr_q;
    data_wdata_o   = data_wdata_q;
  end

endmodule

// File: doc/miriscv_lsu.md
MIRISCV_LSU -- requirements
Module: miriscv_lsu

Interface
REQ-001 Parameter: ADDR_W, default 32, width of lsu_addr_i/data_addr_o.
REQ-002 Parameter: MISALIGNED_EN, default 1; 1 = word-crossing accesses split into two bus beats, 0 = misaligned accesses rejected with error.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 lsu_req_i  in  1  core requests an access; sampled only while lsu_ready_o=1.
REQ-007 lsu_we_i  in  1  1 = store, 0 = load.
REQ-008 lsu_size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-009 lsu_unsigned_i  in  1  load zero-extension select.
REQ-010 lsu_addr_i  in  ADDR_W  byte address.
REQ-011 lsu_wdata_i  in  32  store data, LSB-justified.
REQ-012 lsu_ready_o  out  1  high only in IDLE.
REQ-013 lsu_valid_o  out  1  one-cycle completion pulse.
REQ-014 lsu_rdata_o  out  32  extended load result, valid with lsu_valid_o.
REQ-015 lsu_misalign_o  out  1  error flag, valid with lsu_valid_o.
REQ-016 data_req_o, data_we_o (1), data_be_o (4), data_addr_o (ADDR_W), data_wdata_o (32)  out  registered memory request.
REQ-017 data_gnt_i  in  1  request accepted; data_rvalid_i  in  1  response (loads and stores); data_rdata_i  in  32.

Function
REQ-018 FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE, ERR.
REQ-019 IDLE & lsu_req_i: latch inputs; k = addr[1:0], n = byte count; next state REQ1, or ERR if MISALIGNED_EN=0 and addr not a multiple of n.
REQ-020 split = (k+n > 4); split is possible only when MISALIGNED_EN=1.
REQ-021 REQ1: data_req_o=1, addr = {addr[ADDR_W-1:2],2'b00}, be1 = (mask(n)<<k)[3:0], wdata = wdata rotated left by 8k; on data_gnt_i go to WAIT1.
REQ-022 While data_req_o=1 and data_gnt_i=0, data_addr_o/be/we/wdata SHALL be held stable.
REQ-023 WAIT1: on data_rvalid_i, capture data_rdata_i into beat buffer 0; go to REQ2 if split, else DONE.
REQ-024 REQ2: aligned addr+4 (wraps modulo 2^ADDR_W), be2 = mask(n)>>(4-k), same rotated wdata; on gnt go to WAIT2; WAIT2 on rvalid captures buffer 1, then DONE.
REQ-025 DONE: lsu_valid_o=1 for one cycle, lsu_rdata_o = extend(rotr((buf0 & bytemask(be1)) | (buf1 & bytemask(be2)), 8k)); stores return 0; next state IDLE.
REQ-026 Extension: byte/half sign-extended unless lsu_unsigned_i, word unchanged.
REQ-027 ERR: no bus request issued; lsu_valid_o=1, lsu_misalign_o=1, lsu_rdata_o=0 for one cycle, then IDLE.
REQ-028 Latency, zero-wait aligned: accept at cycle T, data_req_o at T+1, rvalid at T+2, lsu_valid_o at T+3; split adds 2 cycles minimum.
REQ-029 data_gnt_i may arrive in the same cycle data_req_o rises; data_rvalid_i arrives at least one cycle after gnt; rvalid in IDLE/REQx and gnt outside REQx SHALL be ignored.
REQ-030 lsu_req_i while not ready SHALL be ignored; the core holds it until accepted.

Reset
REQ-031 rst_i SHALL force IDLE on the next edge from any state, including mid-transaction.
REQ-032 After reset: data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0, lsu_valid_o=0, lsu_misalign_o=0, lsu_rdata_o=0, lsu_ready_o=1, beat buffers=0.
REQ-033 A late rvalid belonging to a transaction aborted by reset SHALL have no effect.

Structure
REQ-034 Size encodings and the FSM state enum SHALL live in the shared miriscv_pkg package.
REQ-035 Byte-enable generation, rotation, merge and extension SHALL be one combinational sub-module, miriscv_lsu_align; the FSM and registers stay in miriscv_lsu.

Verification
REQ-036 Word load at 0x100, gnt same cycle, rdata 0xDEADBEEF -> be=1111, lsu_valid_o at T+3, lsu_rdata_o=0xDEADBEEF.
REQ-037 Signed byte load at 0x103, rdata 0x80000000 -> be=1000, lsu_rdata_o=0xFFFFFF80; with unsigned -> 0x00000080.
REQ-038 Word store 0x11223344 at 0x102, MISALIGNED_EN=1 -> beat1 addr 0x100 be=1100 wdata 0x33441122; beat2 addr 0x104 be=0011 same wdata.
REQ-039 Word load at 0x101, beats return 0xAABBCCDD then 0x11223344 -> lsu_rdata_o=0x44AABBCC.
REQ-040 Half load at 0x101 with MISALIGNED_EN=0 -> no data_req_o, lsu_valid_o and lsu_misalign_o pulse at T+1.
REQ-041 rst_i during WAIT2 with gnt held low 3 cycles -> IDLE next edge, outputs at reset values, rvalid arriving after reset is ignored.
